// File: rtl/led_scan_ctrl_pkg.sv
// Shared definitions for the HUB75-style LED scan controller.
// Holds the FSM state encoding, register field positions and default geometry.
package led_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CLK_LO  = 3'd2,
        ST_CLK_HI  = 3'd3,
        ST_BLANK   = 3'd4,
        ST_LATCH   = 3'd5,
        ST_DISPLAY = 3'd6,
        ST_NEXT    = 3'd7
    } scan_state_t;

    localparam int CTRL_EN_BIT  = 0;
    localparam int DIV_W        = 8;
    localparam int BRIGHT_W     = 16;

    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_PLANE_LSB = 2;
    localparam int ST_PLANE_W   = 2;
    localparam int ST_ROW_LSB   = 8;
    localparam int ST_ROW_W     = 4;
    localparam int ST_FRAME_LSB = 16;
    localparam int ST_FRAME_W   = 16;

    localparam int DEF_COLS     = 64;
    localparam int DEF_ROW_BITS = 4;
    localparam int DEF_PLANES   = 4;

endpackage

// File: rtl/led_scan_ctrl_scan_timer.sv
// Loadable down-counter shared by the hub_clk, latch and OE phases.
// Loading N-1 on state entry makes the state last exactly N cycles.
module scan_timer #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/led_scan_ctrl.sv
// Row/bit-plane scan controller for HUB75 LED panels with binary-coded modulation.
// Reads one framebuffer word per column, shifts it out, latches the row and pulses OE.
module led_scan_ctrl
    import led_scan_ctrl_pkg::*;
#(
    parameter int COLS     = DEF_COLS,
    parameter int ROW_BITS = DEF_ROW_BITS,
    parameter int PLANES   = DEF_PLANES,
    localparam int PL_W    = (PLANES > 1) ? $clog2(PLANES) : 1,
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   ctrl_reg,
    input  logic [31:0]                   div_reg,
    input  logic [31:0]                   bright_reg,
    output logic [31:0]                   status,
    output logic [PL_W+ROW_BITS+COL_W-1:0] fb_addr,
    output logic                          fb_rd,
    input  logic [5:0]                    fb_rdata,
    output logic                          hub_r1,
    output logic                          hub_g1,
    output logic                          hub_b1,
    output logic                          hub_r2,
    output logic                          hub_g2,
    output logic                          hub_b2,
    output logic                          hub_clk,
    output logic                          hub_lat,
    output logic                          hub_oe_n,
    output logic [ROW_BITS-1:0]           hub_addr,
    output scan_state_t                   o_dbg_state
);

    // Wide enough for bright << (PLANES-1) without overflow, never below 18 bits.
    localparam int OE_W = (BRIGHT_W + PLANES - 1 > 18) ? BRIGHT_W + PLANES - 1 : 18;

    scan_state_t           r_state;
    scan_state_t           w_next;
    logic [PL_W-1:0]       r_plane;
    logic [ROW_BITS-1:0]   r_row;
    logic [COL_W-1:0]      r_col;
    logic [15:0]           r_frame;
    logic [DIV_W-1:0]      r_div;
    logic [BRIGHT_W-1:0]   r_bright;
    logic [5:0]            r_hub_data;
    logic [ROW_BITS-1:0]   r_hub_addr;
    logic                  r_rd_d;

    logic                  w_en;
    logic                  w_col_last;
    logic                  w_plane_last;
    logic                  w_row_last;
    logic                  w_frame_done;
    logic                  w_sample_regs;
    logic [OE_W-1:0]       w_oe_len;
    logic [OE_W-1:0]       w_div_m1;
    logic                  w_tmr_load;
    logic [OE_W-1:0]       w_tmr_value;
    logic                  w_tmr_done;
    logic                  w_unused_bits;

    assign w_en         = ctrl_reg[CTRL_EN_BIT];
    assign w_col_last   = (r_col == COL_W'(COLS - 1));
    assign w_plane_last = (r_plane == PL_W'(PLANES - 1));
    assign w_row_last   = (r_row == '1);
    assign w_frame_done = w_plane_last && w_row_last;
    assign w_oe_len     = OE_W'(r_bright) << r_plane;
    assign w_div_m1     = OE_W'(r_div) - OE_W'(1);
    assign w_sample_regs = (w_next == ST_FETCH) &&
                           ((r_state == ST_IDLE) || (r_state == ST_NEXT));
    assign w_unused_bits = &{1'b0, ctrl_reg[31:1], div_reg[31:DIV_W], bright_reg[31:BRIGHT_W]};

    scan_timer #(.W(OE_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_done  (w_tmr_done)
    );

    always_comb begin
        w_next      = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_en) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_next      = ST_CLK_LO;
                w_tmr_load  = 1'b1;
                w_tmr_value = w_div_m1;
            end
            ST_CLK_LO: begin
                if (w_tmr_done) begin
                    w_next      = ST_CLK_HI;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = w_div_m1;
                end
            end
            ST_CLK_HI: begin
                if (w_tmr_done) w_next = w_col_last ? ST_BLANK : ST_FETCH;
            end
            ST_BLANK: begin
                w_next      = ST_LATCH;
                w_tmr_load  = 1'b1;
                w_tmr_value = w_div_m1;
            end
            ST_LATCH: begin
                // A zero-length plane skips DISPLAY so OE never pulses low.
                if (w_tmr_done) begin
                    if (w_oe_len == '0) begin
                        w_next = ST_NEXT;
                    end else begin
                        w_next      = ST_DISPLAY;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = w_oe_len - OE_W'(1);
                    end
                end
            end
            ST_DISPLAY: begin
                if (w_tmr_done) w_next = ST_NEXT;
            end
            ST_NEXT: begin
                w_next = (w_frame_done && !w_en) ? ST_IDLE : ST_FETCH;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_plane    <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_frame    <= '0;
            r_div      <= DIV_W'(1);
            r_bright   <= '0;
            r_hub_data <= '0;
            r_hub_addr <= '0;
            r_rd_d     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rd_d  <= (r_state == ST_FETCH);
            // fb_rdata is valid exactly one cycle after the FETCH strobe.
            if (r_rd_d) r_hub_data <= fb_rdata;
            if (w_sample_regs) begin
                r_div    <= (div_reg[DIV_W-1:0] == '0) ? DIV_W'(1) : div_reg[DIV_W-1:0];
                r_bright <= bright_reg[BRIGHT_W-1:0];
            end
            if ((r_state == ST_CLK_HI) && w_tmr_done) begin
                r_col <= w_col_last ? '0 : r_col + COL_W'(1);
                if (w_col_last) r_hub_addr <= r_row;
            end
            if (r_state == ST_NEXT) begin
                if (w_plane_last) begin
                    r_plane <= '0;
                    r_row   <= w_row_last ? '0 : r_row + ROW_BITS'(1);
                    if (w_row_last) r_frame <= r_frame + 16'd1;
                end else begin
                    r_plane <= r_plane + PL_W'(1);
                end
            end
        end
    end

    assign fb_rd    = (r_state == ST_FETCH);
    assign fb_addr  = {r_plane, r_row, r_col};
    assign {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} = r_hub_data;
    assign hub_clk  = (r_state == ST_CLK_HI);
    assign hub_lat  = (r_state == ST_LATCH);
    assign hub_oe_n = (r_state != ST_DISPLAY);
    assign hub_addr = r_hub_addr;
    assign o_dbg_state = r_state;

    always_comb begin
        status = '0;
        status[ST_BUSY_BIT] = (r_state != ST_IDLE);
        status[ST_PLANE_LSB +: ST_PLANE_W] = ST_PLANE_W'(r_plane);
        status[ST_ROW_LSB +: ST_ROW_W]     = ST_ROW_W'(r_row);
        status[ST_FRAME_LSB +: ST_FRAME_W] = r_frame;
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl on a 4-column, 2-row, 2-plane panel.
// Expected hub data, latch rows and OE windows are queued per frame and checked by a monitor.
`timescale 1ns/1ps
module tb_led_scan_ctrl;
    import led_scan_ctrl_pkg::*;

    localparam int COLS     = 4;
    localparam int ROW_BITS = 1;
    localparam int PLANES   = 2;
    localparam int AW       = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [31:0]         ctrl_reg = '0;
    logic [31:0]         div_reg = '0;
    logic [31:0]         bright_reg = '0;
    logic [31:0]         status;
    logic [AW-1:0]       fb_addr;
    logic                fb_rd;
    logic [5:0]          fb_rdata = '0;
    logic                hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
    logic                hub_clk, hub_lat, hub_oe_n;
    logic [ROW_BITS-1:0] hub_addr;
    scan_state_t         dbg_state;

    led_scan_ctrl #(.COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES)) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_reg    (ctrl_reg),
        .div_reg     (div_reg),
        .bright_reg  (bright_reg),
        .status      (status),
        .fb_addr     (fb_addr),
        .fb_rd       (fb_rd),
        .fb_rdata    (fb_rdata),
        .hub_r1      (hub_r1),
        .hub_g1      (hub_g1),
        .hub_b1      (hub_b1),
        .hub_r2      (hub_r2),
        .hub_g2      (hub_g2),
        .hub_b2      (hub_b2),
        .hub_clk     (hub_clk),
        .hub_lat     (hub_lat),
        .hub_oe_n    (hub_oe_n),
        .hub_addr    (hub_addr),
        .o_dbg_state (dbg_state)
    );

    // Clock and framebuffer model (registered read, one cycle latency)
    always #5 clk = ~clk;

    logic [5:0] fb_mem [16];
    always @(posedge clk) if (fb_rd) fb_rdata <= fb_mem[fb_addr];

    // Scoreboard state
    logic [5:0]          data_q[$];
    logic [ROW_BITS-1:0] row_q[$];
    logic [17:0]         oe_q[$];
    logic [1:0]          oe_rp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int exp_div  = 1;
    bit mon_en   = 1'b0;
    int busy_cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic empty_pop(input string name);
        n_checks++;
        $display("FAIL %s: DUT produced an output with no queued expectation", name);
    endtask

    // Order of row-planes: plane advances first, row on plane wrap.
    task automatic push_frame(input int b_first, input int b_rest);
        int rp;
        int n;
        rp = 0;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < PLANES; p++) begin
                for (int c = 0; c < COLS; c++) data_q.push_back(fb_mem[p * 8 + r * 4 + c]);
                row_q.push_back(ROW_BITS'(r));
                n = ((rp == 0) ? b_first : b_rest) << p;
                if (n != 0) begin
                    oe_q.push_back(18'(n));
                    oe_rp_q.push_back({1'(r), 1'(p)});
                end
                rp++;
            end
        end
    endtask

    task automatic drain(input string tag);
        check({tag, "_data_left"}, data_q.size(), 0);
        check({tag, "_row_left"}, row_q.size(), 0);
        check({tag, "_oe_left"}, oe_q.size(), 0);
        data_q.delete();
        row_q.delete();
        oe_q.delete();
        oe_rp_q.delete();
    endtask

    task automatic wait_busy(input bit v, input int budget, input string name);
        int t;
        t = 0;
        while (status[0] != v && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, status[0], v);
    endtask

    // Monitor: pops and compares whenever the panel interface shows an event
    logic prev_clk = 1'b0, prev_lat = 1'b0, prev_oe = 1'b1;
    int hi_len = 0, lat_len = 0, oe_len = 0, gap = 0, pulses = 0;
    logic [1:0] oe_rp = '0;
    logic [17:0] exp_len;

    always @(negedge clk) begin
        if (!rst || !mon_en) begin
            hi_len = 0; lat_len = 0; oe_len = 0; gap = 0; pulses = 0;
        end else begin
            if (fb_rd) gap = 0;
            else gap++;
            if (hub_clk && !prev_clk) begin
                check("fetch_to_clk_rise", gap, exp_div + 1);
                if (data_q.size() == 0) empty_pop("hub_data");
                else check("hub_data", {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}, data_q.pop_front());
                pulses++;
            end
            if (hub_clk) hi_len++;
            if (!hub_clk && prev_clk) begin
                check("clk_high_len", hi_len, exp_div);
                hi_len = 0;
            end
            if (hub_lat && !prev_lat) begin
                check("pulses_per_row", pulses, COLS);
                pulses = 0;
                if (row_q.size() == 0) empty_pop("hub_addr");
                else check("hub_addr", hub_addr, row_q.pop_front());
            end
            if (hub_lat) lat_len++;
            if (!hub_lat && prev_lat) begin
                check("lat_len", lat_len, exp_div);
                lat_len = 0;
            end
            if (!hub_oe_n && prev_oe) oe_rp = {status[8], status[2]};
            if (!hub_oe_n) oe_len++;
            if (hub_oe_n && !prev_oe) begin
                if (oe_q.size() == 0) empty_pop("oe_window");
                else begin
                    exp_len = oe_q.pop_front();
                    check("oe_len", oe_len, exp_len);
                    check("oe_row_plane", oe_rp, oe_rp_q.pop_front());
                end
                oe_len = 0;
            end
        end
        prev_clk = hub_clk;
        prev_lat = hub_lat;
        prev_oe  = hub_oe_n;
    end

    always @(negedge clk) if (status[0]) busy_cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 16; a++) fb_mem[a] = 6'(a * 5 + 1);

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_status", status, 0);
        check("rst_oe_n", hub_oe_n, 1);
        check("rst_fb_rd", fb_rd, 0);
        check("rst_hub_clk", hub_clk, 0);
        check("rst_hub_lat", hub_lat, 0);
        check("rst_hub_addr", hub_addr, 0);
        check("rst_hub_data", {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_disabled", status[0], 0);

        // div=2, bright=3: single frame, 114 busy cycles
        div_reg = 2; bright_reg = 3; exp_div = 2;
        push_frame(3, 3);
        busy_cyc = 0; mon_en = 1'b1;
        ctrl_reg = 1;
        wait_busy(1, 20, "a_start");
        ctrl_reg = 0;
        wait_busy(0, 1000, "a_done");
        check("a_busy_cycles", busy_cyc, 114);
        check("a_frame", status[31:16], 1);
        check("a_row_plane", status[11:2], 0);
        drain("a");

        // div=1, bright=2: enable dropped during row 1 of the second frame
        div_reg = 1; bright_reg = 2; exp_div = 1;
        push_frame(2, 2);
        push_frame(2, 2);
        ctrl_reg = 1;
        wait_busy(1, 20, "b_start");
        begin
            int t;
            t = 0;
            while (status[31:16] != 16'd2 && t < 1000) begin @(negedge clk); t++; end
            check("b_first_frame", status[31:16], 2);
            t = 0;
            while (status[8] != 1'b1 && t < 500) begin @(negedge clk); t++; end
            check("b_row1", status[8], 1);
        end
        ctrl_reg = 0;
        wait_busy(0, 1000, "b_done");
        check("b_frame", status[31:16], 3);
        repeat (5) @(negedge clk);
        check("b_rest_idle", dbg_state, ST_IDLE);
        check("b_busy_low", status[0], 0);
        drain("b");

        // div=0 acts as 1; bright=0 keeps OE high for the whole frame
        div_reg = 0; bright_reg = 0; exp_div = 1;
        push_frame(0, 0);
        busy_cyc = 0;
        ctrl_reg = 1;
        wait_busy(1, 20, "c_start");
        ctrl_reg = 0;
        wait_busy(0, 1000, "c_done");
        check("c_busy_cycles", busy_cyc, 60);
        check("c_frame", status[31:16], 4);
        drain("c");

        // Reset pulsed during DISPLAY
        mon_en = 1'b0;
        div_reg = 1; bright_reg = 5;
        ctrl_reg = 1;
        begin
            int t;
            t = 0;
            while (hub_oe_n != 1'b0 && t < 200) begin @(negedge clk); t++; end
            check("d_oe_low", hub_oe_n, 0);
        end
        #2 rst = 1'b0;
        #1;
        check("d_rst_oe_n", hub_oe_n, 1);
        check("d_rst_status", status, 0);
        check("d_rst_state", dbg_state, ST_IDLE);
        check("d_rst_hub_clk", hub_clk, 0);
        check("d_rst_data", {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}, 0);
        ctrl_reg = 0;
        @(negedge clk);
        mon_en = 1'b1; exp_div = 1;
        push_frame(5, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ctrl_reg = 1;
        wait_busy(1, 20, "d_restart");
        check("d_first_rd", fb_rd, 1);
        check("d_first_addr", fb_addr, 0);
        check("d_first_row_plane", status[11:2], 0);
        check("d_frame_cleared", status[31:16], 0);
        ctrl_reg = 0;
        wait_busy(0, 1000, "d_done");
        check("d_frame", status[31:16], 1);
        drain("d");

        // bright_reg 3 -> 10 during the first CLK_HI
        div_reg = 2; bright_reg = 3; exp_div = 2;
        push_frame(3, 10);
        busy_cyc = 0;
        ctrl_reg = 1;
        wait_busy(1, 20, "e_start");
        begin
            int t;
            t = 0;
            while (hub_clk != 1'b1 && t < 50) begin @(negedge clk); t++; end
            check("e_in_clk_hi", dbg_state, ST_CLK_HI);
        end
        bright_reg = 10;
        ctrl_reg = 0;
        wait_busy(0, 1000, "e_done");
        check("e_busy_cycles", busy_cyc, 149);
        check("e_frame", status[31:16], 2);
        drain("e");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
